// File: rtl/mac_ram_unit.sv
// Signed 8x8 multiply-accumulate lane with a 19-bit wrapping accumulator, plus a
// 64 x 19-bit result RAM with a registered, read-first read port.
module mac_ram_unit #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 19,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] mac_a,
  input  logic signed [DATA_W-1:0] mac_b,
  input  logic                     mac_clear,
  output logic signed [ACC_W-1:0]  mac_out,
  input  logic        [ACC_W-1:0]  ram_din,
  input  logic                     ram_we,
  input  logic        [ADDR_W-1:0] ram_addr,
  output logic        [ACC_W-1:0]  ram_dout
);

  localparam int unsigned ProdW = 2 * DATA_W;

  logic signed [ProdW-1:0] product;
  logic signed [ACC_W-1:0] product_ext;
  logic signed [ACC_W-1:0] acc_next;

  logic [ACC_W-1:0] mem [DEPTH];

  always_comb begin
    product     = mac_a * mac_b;
    product_ext = {{(ACC_W - ProdW){product[ProdW-1]}}, product};
    // A clear restarts with this cycle's product rather than zero.
    acc_next    = mac_clear ? product_ext : mac_out + product_ext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mac_out <= '0;
    end else begin
      mac_out <= acc_next;
    end
  end

  // Array contents survive reset; only the write is gated.
  always_ff @(posedge clk) begin
    if (!reset && ram_we) begin
      mem[ram_addr] <= ram_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_dout <= '0;
    end else begin
      ram_dout <= mem[ram_addr];
    end
  end

endmodule

// File: tb/tb_mac_ram_unit.sv
// Self-checking bench for mac_ram_unit: MAC vector table, RAM corner sequences and
// randomized traffic checked against an arithmetic reference model.
module tb_mac_ram_unit;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [7:0] mac_a;
  logic signed [7:0] mac_b;
  logic              mac_clear;
  logic signed [18:0] mac_out;
  logic [18:0]       ram_din;
  logic              ram_we;
  logic [5:0]        ram_addr;
  logic [18:0]       ram_dout;

  mac_ram_unit dut (
    .clk      (clk),
    .reset    (reset),
    .mac_a    (mac_a),
    .mac_b    (mac_b),
    .mac_clear(mac_clear),
    .mac_out  (mac_out),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    bit clr;
    int a;
    int b;
    int exp;
  } mac_vec_t;

  mac_vec_t vecs[$];

  int total = 0;
  int bad   = 0;

  // Reference model state
  int model_acc  = 0;
  int model_dout = 0;
  bit dout_known = 1'b0;
  int mem_m[64];
  bit val_m[64];

  function automatic int wrap19(input longint v);
    longint w;
    w = v & 64'h7FFFF;
    if (w >= 64'sd262144) w = w - 64'sd524288;
    return int'(w);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, $signed(act), act,
               $signed(exp), exp);
    end
  endtask

  task automatic check_mac(input string name, input int exp);
    check(name, 32'($signed(mac_out)), exp);
  endtask

  task automatic check_ram(input string name, input int exp);
    check(name, {13'b0, ram_dout}, exp & 32'h7FFFF);
  endtask

  // Apply one cycle of inputs, advance the model, and return #1 after the edge.
  task automatic tick(input bit rst, input bit clr, input int a, input int b,
                      input bit we, input int addr, input int din);
    reset     = rst;
    mac_clear = clr;
    mac_a     = 8'(a);
    mac_b     = 8'(b);
    ram_we    = we;
    ram_addr  = 6'(addr);
    ram_din   = 19'(din);
    @(posedge clk);
    if (rst) begin
      model_acc  = 0;
      model_dout = 0;
      dout_known = 1'b1;
    end else begin
      dout_known = val_m[addr];
      model_dout = mem_m[addr];
      if (we) begin
        mem_m[addr] = wrap19(longint'(din));
        val_m[addr] = 1'b1;
      end
      model_acc = clr ? wrap19(longint'(a * b)) : wrap19(longint'(model_acc) + a * b);
    end
    #1;
  endtask

  function automatic void add_vec(input bit rst, input bit clr, input int a, input int b,
                                  input int exp);
    mac_vec_t v;
    v.rst = rst; v.clr = clr; v.a = a; v.b = b; v.exp = exp;
    vecs.push_back(v);
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_m[i] = 0;
      val_m[i] = 1'b0;
    end
    reset = 1'b1; mac_clear = 1'b0; mac_a = '0; mac_b = '0;
    ram_we = 1'b0; ram_addr = '0; ram_din = '0;

    // MAC vector table
    add_vec(1, 0, 0, 0, 0);
    add_vec(1, 0, 0, 0, 0);
    add_vec(0, 1, 3, -4, -12);
    add_vec(0, 0, 5, 6, 18);
    for (int i = 1; i <= 16; i++) begin
      add_vec(0, i == 1, -128, -128, (i == 16) ? -262144 : 16384 * i);
    end
    add_vec(0, 1, 1, 1, 1);
    add_vec(0, 0, 1, 1, 2);
    add_vec(0, 0, 1, 1, 3);
    add_vec(1, 0, 9, 9, 0);
    add_vec(0, 0, 2, 7, 14);
    add_vec(0, 0, 127, -128, 14 - 16256);
    add_vec(0, 1, -1, -1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].rst, vecs[i].clr, vecs[i].a, vecs[i].b, 1'b0, 0, 0);
      check_mac($sformatf("mac_vec%0d", i), vecs[i].exp);
    end

    // RAM: basic write/read
    tick(0, 1, 0, 0, 1, 5, 74565);
    tick(0, 1, 0, 0, 1, 63, -1);
    tick(0, 1, 0, 0, 0, 5, 0);
    check_ram("ram_rd5", 74565);
    tick(0, 1, 0, 0, 0, 63, 0);
    check_ram("ram_rd63", -1);

    // Fill all addresses, then read back
    for (int i = 0; i < 64; i++) tick(0, 1, 0, 0, 1, i, i);
    for (int i = 0; i < 64; i++) begin
      tick(0, 1, 0, 0, 0, i, 0);
      check_ram($sformatf("ram_fill%0d", i), i);
    end

    // Read-during-write is read-first
    tick(0, 1, 0, 0, 1, 9, 100);
    tick(0, 1, 0, 0, 1, 9, 200);
    check_ram("raw_old", 100);
    tick(0, 1, 0, 0, 0, 9, 0);
    check_ram("raw_new", 200);

    // Write suppressed during reset
    tick(1, 0, 0, 0, 1, 9, 555);
    check_ram("rst_dout", 0);
    check_mac("rst_mac", 0);
    tick(0, 1, 0, 0, 0, 9, 0);
    check_ram("rst_nowrite", 200);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      bit rst_r;
      bit clr_r;
      bit we_r;
      int a_r;
      int b_r;
      int addr_r;
      int din_r;
      rst_r  = ($urandom_range(0, 39) == 0);
      clr_r  = ($urandom_range(0, 3) == 0);
      we_r   = $urandom_range(0, 1);
      a_r    = $urandom_range(0, 255) - 128;
      b_r    = $urandom_range(0, 255) - 128;
      addr_r = $urandom_range(0, 63);
      din_r  = $urandom_range(0, 524287);
      tick(rst_r, clr_r, a_r, b_r, we_r, addr_r, din_r);
      check_mac($sformatf("rnd_mac%0d", n), model_acc);
      if (dout_known) check_ram($sformatf("rnd_ram%0d", n), model_dout);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
